// File: rtl/mmio_input_hub.sv
// Memory-mapped hub of NUM_CH input FIFOs with per-channel STATUS/CTRL registers and a shared irq.
// Build macro MMIO_INPUT_HUB_WATERMARK_EN adds a per-channel irq watermark held in CTRL[15:8].
module mmio_input_hub #(
  parameter int          NUM_CH    = 2,
  parameter int          DEPTH     = 16,
  parameter int          DW        = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [NUM_CH*DW-1:0] in_data,
  input  logic [31:0]          cpu_addr,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [31:0]          cpu_wdata,
  output logic                 hit,
  output logic [31:0]          cpu_rdata,
  output logic [NUM_CH-1:0]    ovf,
  output logic                 irq
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] WIN = 32'(NUM_CH * 16);

  logic [31:0] offset;
  logic [2:0]  ch;
  logic [1:0]  rsel;
  logic        rd_ok, wr_ok;
  logic        unused_bits;

  logic [DW-1:0] mem [NUM_CH][DEPTH];
  logic [AW-1:0] wr_ptr [NUM_CH];
  logic [AW-1:0] rd_ptr [NUM_CH];
  logic [CW-1:0] count  [NUM_CH];
  logic [NUM_CH-1:0] irq_en, empty, full, pop, accept, flush;
  logic [NUM_CH-1:0] ovf_set, ovf_clr, ctrl_wr, irq_term;
  logic [31:0] rd_val;
`ifdef MMIO_INPUT_HUB_WATERMARK_EN
  logic [7:0] wm [NUM_CH];
`endif

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign offset      = cpu_addr - BASE_ADDR;
  assign ch          = offset[6:4];
  assign rsel        = offset[3:2];
  assign hit         = (offset < WIN);
  assign rd_ok       = cpu_rd & ~cpu_wr & hit;
  assign wr_ok       = cpu_wr & hit;
  assign unused_bits = ^{offset[31:7], offset[1:0], cpu_wdata};

  always_comb begin
    empty    = '0;
    full     = '0;
    ctrl_wr  = '0;
    flush    = '0;
    ovf_clr  = '0;
    pop      = '0;
    accept   = '0;
    ovf_set  = '0;
    irq_term = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c]   = (count[c] == '0);
      full[c]    = (count[c] == CW'(DEPTH));
      ctrl_wr[c] = wr_ok & (ch == 3'(c)) & (rsel == 2'd2);
      flush[c]   = ctrl_wr[c] & cpu_wdata[0];
      ovf_clr[c] = ctrl_wr[c] & cpu_wdata[1];
      pop[c]     = rd_ok & (ch == 3'(c)) & (rsel == 2'd0) & ~empty[c];
      // A pop frees the slot, so a push into a full FIFO on the same edge still lands.
      accept[c]  = in_valid[c] & (~full[c] | pop[c]) & ~flush[c];
      ovf_set[c] = in_valid[c] & full[c] & ~pop[c] & ~flush[c];
`ifdef MMIO_INPUT_HUB_WATERMARK_EN
      irq_term[c] = irq_en[c] &
                    (32'(count[c]) >= ((wm[c] == 8'd0) ? 32'd1 : 32'(wm[c])));
`else
      irq_term[c] = irq_en[c] & ~empty[c];
`endif
    end
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 3'(c)) begin
        case (rsel)
          2'd0: rd_val = empty[c] ? 32'h8000_0000 : 32'(mem[c][rd_ptr[c]]);
          2'd1: rd_val = {12'b0, irq_en[c], ovf[c], full[c], empty[c], 16'(count[c])};
          2'd2: begin
            rd_val = {29'b0, irq_en[c], 2'b0};
`ifdef MMIO_INPUT_HUB_WATERMARK_EN
            rd_val[15:8] = wm[c];
`endif
          end
          default: rd_val = '0;
        endcase
      end
    end
  end

  // FIFO storage carries no reset; contents are meaningless once pointers clear.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (accept[c]) mem[c][wr_ptr[c]] <= in_data[c*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
`ifdef MMIO_INPUT_HUB_WATERMARK_EN
        wm[c]     <= 8'd1;
`endif
      end
      ovf       <= '0;
      irq_en    <= '0;
      irq       <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          count[c]  <= '0;
        end else begin
          if (accept[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
          if (pop[c])    rd_ptr[c] <= rd_ptr[c] + AW'(1);
          count[c] <= count[c] + CW'(accept[c]) - CW'(pop[c]);
        end
        if (ovf_set[c])      ovf[c] <= 1'b1;
        else if (ovf_clr[c]) ovf[c] <= 1'b0;
        if (ctrl_wr[c]) begin
          irq_en[c] <= cpu_wdata[2];
`ifdef MMIO_INPUT_HUB_WATERMARK_EN
          wm[c]     <= cpu_wdata[15:8];
`endif
        end
      end
      irq <= |irq_term;
      if (cpu_rd) cpu_rdata <= (hit & ~cpu_wr) ? rd_val : 32'h0;
    end
  end

endmodule

// File: tb/tb_mmio_input_hub.sv
// Scoreboard bench for mmio_input_hub: directed plan plus random traffic against a queue-based model.
module tb_mmio_input_hub;
  localparam int          NUM_CH = 2;
  localparam int          DEPTH  = 16;
  localparam int          DW     = 8;
  localparam logic [31:0] BASE   = 32'h0000_4000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_CH-1:0]    in_valid = '0;
  logic [NUM_CH*DW-1:0] in_data = '0;
  logic [31:0]          cpu_addr = '0;
  logic                 cpu_rd = 1'b0;
  logic                 cpu_wr = 1'b0;
  logic [31:0]          cpu_wdata = '0;
  logic                 hit;
  logic [31:0]          cpu_rdata;
  logic [NUM_CH-1:0]    ovf;
  logic                 irq;

  always #5 clk = ~clk;

  mmio_input_hub #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DW(DW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .hit(hit), .cpu_rdata(cpu_rdata), .ovf(ovf), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queues per channel plus register shadows.
  logic [DW-1:0]     m_q [NUM_CH][$];
  logic [NUM_CH-1:0] m_ovf = '0;
  logic [NUM_CH-1:0] m_en = '0;
  logic [7:0]        m_wm [NUM_CH];
  logic              m_irq = 1'b0;
  logic [31:0]       exp_q [$];
  logic              rd_seen;
  logic              chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic irq_want(input int c);
`ifdef MMIO_INPUT_HUB_WATERMARK_EN
    int thr;
    thr = (m_wm[c] == 8'd0) ? 1 : int'(m_wm[c]);
    return m_en[c] && (m_q[c].size() >= thr);
`else
    return m_en[c] && (m_q[c].size() > 0);
`endif
  endfunction

  function automatic logic [31:0] model_read(input int ch, input int rg);
    logic [31:0] e;
    int sz;
    e  = '0;
    sz = m_q[ch].size();
    case (rg)
      0: e = (sz > 0) ? 32'(m_q[ch][0]) : 32'h8000_0000;
      1: begin
        e[19]   = m_en[ch];
        e[18]   = m_ovf[ch];
        e[17]   = (sz == DEPTH);
        e[16]   = (sz == 0);
        e[15:0] = 16'(sz);
      end
      2: begin
        e[2] = m_en[ch];
`ifdef MMIO_INPUT_HUB_WATERMARK_EN
        e[15:8] = m_wm[ch];
`endif
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_q[c].delete();
      m_wm[c] = 8'd1;
    end
    m_ovf = '0;
    m_en  = '0;
    m_irq = 1'b0;
  endfunction

  // One bus/push cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DW-1:0] d,
                      input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata);
    logic [31:0] off;
    logic        inwin, irq_nxt, sel, popped;
    int          ch, rg;
    in_valid = v; in_data = d; cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    off   = addr - BASE;
    inwin = (off < 32'(NUM_CH * 16));
    ch    = int'(off[6:4]);
    rg    = int'(off[3:2]);
    #1 check("hit", 32'(hit), 32'(inwin));
    if (rd) exp_q.push_back((inwin && !wr) ? model_read(ch, rg) : 32'h0);
    irq_nxt = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (irq_want(c)) irq_nxt = 1'b1;
    @(posedge clk);
    m_irq = irq_nxt;
    for (int c = 0; c < NUM_CH; c++) begin
      sel    = inwin && (ch == c);
      popped = rd && !wr && sel && (rg == 0) && (m_q[c].size() > 0);
      if (wr && sel && rg == 2) begin
        if (wdata[1]) m_ovf[c] = 1'b0;
        m_en[c] = wdata[2];
        m_wm[c] = wdata[15:8];
      end
      if (wr && sel && rg == 2 && wdata[0]) begin
        m_q[c].delete();
      end else begin
        if (popped) void'(m_q[c].pop_front());
        if (v[c]) begin
          if (m_q[c].size() < DEPTH) m_q[c].push_back(d[c*DW +: DW]);
          else m_ovf[c] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic push(input int c, input logic [DW-1:0] val);
    step(NUM_CH'(1) << c, (NUM_CH*DW)'(val) << (c * DW), 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    step('0, '0, 1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    step('0, '0, 1'b0, 1'b1, addr, data);
  endtask

  // Monitor: a load issued in one cycle presents cpu_rdata after the following edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else        rd_seen <= cpu_rd;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rdata: got %08h with no expected entry queued", cpu_rdata);
        end else begin
          check("rdata", cpu_rdata, exp_q.pop_front());
        end
      end
      check("irq", 32'(irq), 32'(m_irq));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [NUM_CH-1:0]    rv;
    logic [NUM_CH*DW-1:0] rdv;
    logic [31:0]          ra, rw;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Basic push/read, empty marker, STATUS
    rd(BASE + 32'h4);
    push(0, 8'h41);
    push(0, 8'h42);
    rd(BASE); rd(BASE); rd(BASE);
    rd(BASE + 32'h4);

    // Overflow on ch1, drain in order, clear ovf
    for (int i = 0; i < 17; i++) push(1, 8'(8'h10 + i));
    rd(BASE + 32'h14);
    for (int i = 0; i < 16; i++) rd(BASE + 32'h10);
    wr(BASE + 32'h18, 32'h2);
    rd(BASE + 32'h14);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(0, 8'(8'h60 + i));
    step(2'b01, {8'h00, 8'h55}, 1'b1, 1'b0, BASE, 32'h0);
    rd(BASE + 32'h4);
    for (int i = 0; i < 16; i++) rd(BASE);
    rd(BASE + 32'h4);

    // irq enable, push, drain
    wr(BASE + 32'h8, 32'h4);
    rd(BASE + 32'h8);
    push(0, 8'h77);
    idle(); idle();
    rd(BASE);
    idle(); idle();

    // Flush coinciding with push, including from a full FIFO
    push(0, 8'h01); push(0, 8'h02);
    step(2'b01, {8'h00, 8'h99}, 1'b0, 1'b1, BASE + 32'h8, 32'h1);
    rd(BASE + 32'h4);
    rd(BASE);
    for (int i = 0; i < 16; i++) push(0, 8'(i));
    step(2'b01, {8'h00, 8'hAA}, 1'b0, 1'b1, BASE + 32'h8, 32'h1);
    rd(BASE + 32'h4);

    // Out-of-window and reserved accesses, simultaneous rd/wr
    push(1, 8'h33);
    rd(BASE + 32'h20);
    rd(BASE - 32'h4);
    wr(BASE + 32'h28, 32'h7);
    rd(BASE + 32'hC);
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    step('0, '0, 1'b1, 1'b1, BASE + 32'h18, 32'h4);
    rd(BASE + 32'h14);
    rd(BASE + 32'h10);
    rd(BASE + 32'h18);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) rv[c] = ($urandom_range(0, 99) < 45);
      rdv = '0;
      for (int c = 0; c < NUM_CH; c++) rdv[c*DW +: DW] = DW'($urandom);
      ra = BASE + {25'b0, 3'($urandom_range(0, 2)), 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 99) < 3) ra = $urandom;
      rw = $urandom & 32'h0000_FF06;
      if ($urandom_range(0, 99) < 15) rw[0] = 1'b1;
      step(rv, rdv, ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 8), ra, rw);
    end

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 17; i++) push(1, 8'(i));
    wr(BASE + 32'h18, 32'h4);
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_ovf", 32'(ovf), 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_rdata", cpu_rdata, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(BASE + 32'h14);
    rd(BASE + 32'h10);
    idle(); idle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
